// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches 32-bit words from a small program memory,
// issues memory/compute commands downstream and handles jumps, branches and halt.
module instr_sequencer #(
  parameter int PROG_DEPTH = 64,
  parameter int PC_W       = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [31:0]     prog_data,
  input  logic            start,
  input  logic            zo_in,
  input  logic            no_in,
  output logic [15:0]     command,
  output logic [15:0]     number,
  output logic [15:0]     address,
  output logic            issue_valid,
  output logic            busy,
  output logic            halted,
  output logic [PC_W-1:0] pc
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_HALTED = 3'd5;

  localparam logic [3:0] OP_STORE   = 4'h2;
  localparam logic [3:0] OP_LOAD    = 4'h3;
  localparam logic [3:0] OP_COMPUTE = 4'h4;
  localparam logic [3:0] OP_JMP     = 4'h8;
  localparam logic [3:0] OP_JZ      = 4'h9;
  localparam logic [3:0] OP_JN      = 4'hA;
  localparam logic [3:0] OP_HALT    = 4'hF;

  logic [31:0]     mem [PROG_DEPTH];
  logic [31:0]     ir;
  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] jump_target;
  logic            z_f;
  logic            n_f;
  logic            z_nxt;
  logic            n_nxt;
  logic            stopped;
  logic [3:0]      ir_op;
  logic            rsvd_unused;

  assign ir_op       = ir[31:28];
  assign jump_target = ir[PC_W-1:0];
  assign pc_inc      = pc + PC_W'(1);
  assign stopped     = (state == S_IDLE) || (state == S_HALTED);
  assign busy        = !stopped;
  assign halted      = (state == S_HALTED);
  assign rsvd_unused = ^ir[19:16];

  // NOTE: program memory and the instruction register carry no reset; reset
  // must leave the loaded program intact, and ir is always reloaded before use.
  always_ff @(posedge clk) begin
    if (prog_we && stopped) begin
      mem[prog_addr] <= prog_data;
    end
    if (state == S_FETCH) begin
      ir <= mem[pc];
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    z_nxt     = z_f;
    n_nxt     = n_f;
    case (state)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_nxt = S_FETCH;
          pc_nxt    = '0;
          z_nxt     = 1'b0;
          n_nxt     = 1'b0;
        end
      end
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        case (ir_op)
          OP_STORE, OP_LOAD, OP_COMPUTE: state_nxt = S_ISSUE;
          OP_JMP: begin
            state_nxt = S_FETCH;
            pc_nxt    = jump_target;
          end
          OP_JZ: begin
            state_nxt = S_FETCH;
            pc_nxt    = z_f ? jump_target : pc_inc;
          end
          OP_JN: begin
            state_nxt = S_FETCH;
            pc_nxt    = n_f ? jump_target : pc_inc;
          end
          OP_HALT: state_nxt = S_HALTED;
          default: begin
            state_nxt = S_FETCH;
            pc_nxt    = pc_inc;
          end
        endcase
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        state_nxt = S_FETCH;
        pc_nxt    = pc_inc;
        // Only COMPUTE results update the branch flags.
        if (ir_op == OP_COMPUTE) begin
          z_nxt = zo_in;
          n_nxt = no_in;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      z_f         <= 1'b0;
      n_f         <= 1'b0;
      issue_valid <= 1'b0;
      command     <= '0;
      number      <= '0;
      address     <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      z_f         <= z_nxt;
      n_f         <= n_nxt;
      issue_valid <= (state_nxt == S_ISSUE);
      // Issue fields are registered on entry to ISSUE and then held.
      if (state_nxt == S_ISSUE) begin
        command <= {ir_op, 12'h000};
        number  <= ir[15:0];
        address <= {8'h00, ir[27:20]};
      end
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: an instruction-level timing model
// predicts pc, issue and halt behaviour for every cycle of each program run.
module tb_instr_sequencer;

  localparam int DEPTH = 64;
  localparam int PW    = 6;
  localparam int B     = 160;

  logic          clk = 1'b0;
  logic          rst;
  logic          prog_we;
  logic [PW-1:0] prog_addr;
  logic [31:0]   prog_data;
  logic          start;
  logic          zo_in;
  logic          no_in;
  logic [15:0]   command;
  logic [15:0]   number;
  logic [15:0]   address;
  logic          issue_valid;
  logic          busy;
  logic          halted;
  logic [PW-1:0] pc;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] prog_m [DEPTH];
  logic [15:0] last_cmd;
  logic [15:0] last_num;
  logic [15:0] last_addr;
  bit          zo_seq [B];
  bit          no_seq [B];

  instr_sequencer #(.PROG_DEPTH(DEPTH), .PC_W(PW)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .zo_in(zo_in), .no_in(no_in),
    .command(command), .number(number), .address(address),
    .issue_valid(issue_valid), .busy(busy), .halted(halted), .pc(pc)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [7:0] a,
                                     input logic [15:0] imm);
    return {op, a, 4'h0, imm};
  endfunction

  function automatic logic [56:0] observed();
    return {issue_valid, halted, busy, pc, command, number, address};
  endfunction

  // Tasks start and end 1 time unit after a rising edge.
  task automatic write_word(input logic [PW-1:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(posedge clk); #1;
    prog_we = 1'b0;
    prog_m[a] = d;
  endtask

  // Runs the stored program from a start pulse and checks every cycle.
  // zo_mode: 0/1 constant zo_in, 2 random. inj_cycle >= 0 injects a write to
  // word 2 plus a start pulse in that (busy) cycle. co_we writes word 0 together
  // with the start pulse.
  task automatic run_program(input int zo_mode, input int inj_cycle, input bit co_we,
                             input logic [31:0] co_data, input string tag);
    bit          ev [B];
    bit          eh [B];
    logic [15:0] ic [B];
    logic [15:0] inum [B];
    logic [15:0] ia [B];
    logic [PW-1:0] ep [B];
    logic [15:0] ec [B];
    logic [15:0] en [B];
    logic [15:0] ea [B];
    logic [15:0] hc, hn, ha;
    logic [31:0] w;
    logic [3:0]  op;
    logic [56:0] exp_v, obs_v;
    int t, pcm, nxt, dur, halt_at, last;
    bit z, n, is_halt;

    if (co_we) prog_m[0] = co_data;
    for (int c = 0; c < B; c++) begin
      zo_seq[c] = (zo_mode == 2) ? 1'($urandom_range(0, 1)) : (zo_mode == 1);
      no_seq[c] = 1'($urandom_range(0, 1));
      ev[c] = 1'b0; eh[c] = 1'b0; ep[c] = '0;
      ic[c] = '0; inum[c] = '0; ia[c] = '0;
    end

    t = 0; pcm = 0; z = 1'b0; n = 1'b0; halt_at = -1;
    while (t < B) begin
      w = prog_m[pcm];
      op = w[31:28];
      nxt = (pcm + 1) % DEPTH;
      dur = 2;
      is_halt = 1'b0;
      if (op == 4'h2 || op == 4'h3 || op == 4'h4) begin
        dur = 4;
        if (t + 2 < B) begin
          ev[t+2] = 1'b1;
          ic[t+2] = {op, 12'h000};
          inum[t+2] = w[15:0];
          ia[t+2] = {8'h00, w[27:20]};
        end
        if (op == 4'h4 && t + 3 < B) begin
          z = zo_seq[t+3];
          n = no_seq[t+3];
        end
      end else if (op == 4'h8) begin
        nxt = int'(w[5:0]);
      end else if (op == 4'h9) begin
        if (z) nxt = int'(w[5:0]);
      end else if (op == 4'hA) begin
        if (n) nxt = int'(w[5:0]);
      end else if (op == 4'hF) begin
        is_halt = 1'b1;
      end
      for (int c = t; c < t + dur && c < B; c++) ep[c] = PW'(pcm);
      if (is_halt) begin
        halt_at = t + 2;
        for (int c = t + 2; c < B; c++) begin
          ep[c] = PW'(pcm);
          eh[c] = 1'b1;
        end
        break;
      end
      pcm = nxt;
      t += dur;
    end

    hc = last_cmd; hn = last_num; ha = last_addr;
    for (int c = 0; c < B; c++) begin
      if (ev[c]) begin hc = ic[c]; hn = inum[c]; ha = ia[c]; end
      ec[c] = hc; en[c] = hn; ea[c] = ha;
    end
    last = (halt_at < 0 || halt_at + 2 >= B) ? B - 1 : halt_at + 2;

    start = 1'b1; prog_we = co_we; prog_addr = '0; prog_data = co_data;
    @(posedge clk); #1;
    start = 1'b0; prog_we = 1'b0;
    for (int k = 0; k <= last; k++) begin
      zo_in = zo_seq[k];
      no_in = no_seq[k];
      if (k == inj_cycle) begin
        prog_we = 1'b1; prog_addr = PW'(2); prog_data = prog_m[2] ^ 32'hF000_0000;
        start = 1'b1;
      end else begin
        prog_we = 1'b0;
        start = 1'b0;
      end
      @(negedge clk);
      exp_v = {ev[k], eh[k], !eh[k], ep[k], ec[k], en[k], ea[k]};
      obs_v = observed();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL %s cycle %0d {valid,halted,busy,pc,cmd,num,addr}: got %h expected %h",
                 tag, k, obs_v, exp_v);
      end
      @(posedge clk); #1;
    end
    prog_we = 1'b0; start = 1'b0;
    last_cmd = ec[last]; last_num = en[last]; last_addr = ea[last];
    if (halt_at < 0) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      last_cmd = '0; last_num = '0; last_addr = '0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; zo_in = 1'b0; no_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (observed() !== 57'd0) begin
      n_bad++;
      $display("FAIL reset_held outputs: got %h expected 0", observed());
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (observed() !== 57'd0) begin
      n_bad++;
      $display("FAIL reset_release outputs: got %h expected 0", observed());
    end
    @(posedge clk); #1;
    last_cmd = '0; last_num = '0; last_addr = '0;
    for (int i = 0; i < DEPTH; i++) write_word(PW'(i), 32'h0);
  endtask

  task automatic test_compute_halt();
    write_word(PW'(0), mk(4'h4, 8'd5, 16'h0003));
    write_word(PW'(1), mk(4'hF, 8'd0, 16'h0000));
    run_program(2, -1, 1'b0, 32'h0, "compute_halt");
    n_cmp++;
    if ({command, number, address, pc, halted} !== {16'h4000, 16'h0003, 16'h0005, 6'd1, 1'b1}) begin
      n_bad++;
      $display("FAIL compute_halt final cmd/num/addr/pc/halted: got %h %h %h %0d %b expected 4000 0003 0005 1 1",
               command, number, address, pc, halted);
    end
  endtask

  task automatic test_branch();
    write_word(PW'(0), mk(4'h4, 8'h11, 16'h0007));
    write_word(PW'(1), mk(4'h9, 8'h00, 16'h0005));
    write_word(PW'(2), mk(4'hF, 8'h00, 16'h0000));
    write_word(PW'(5), mk(4'hF, 8'h00, 16'h0000));
    run_program(1, -1, 1'b0, 32'h0, "jz_taken");
    n_cmp++;
    if (pc !== 6'd5) begin
      n_bad++;
      $display("FAIL jz_taken halt pc: got %0d expected 5", pc);
    end
    run_program(0, -1, 1'b0, 32'h0, "jz_not_taken");
    n_cmp++;
    if (pc !== 6'd2) begin
      n_bad++;
      $display("FAIL jz_not_taken halt pc: got %0d expected 2", pc);
    end
    // Flags left set by a COMPUTE must be cleared by the next start.
    run_program(1, -1, 1'b0, 32'h0, "set_flags");
    write_word(PW'(0), mk(4'h9, 8'h00, 16'h0005));
    run_program(1, -1, 1'b0, 32'h0, "flags_cleared");
    n_cmp++;
    if (pc !== 6'd2) begin
      n_bad++;
      $display("FAIL flags_cleared halt pc: got %0d expected 2", pc);
    end
  endtask

  task automatic test_wrap();
    write_word(PW'(0), mk(4'h8, 8'h00, 16'h003F));
    write_word(PW'(63), mk(4'h0, 8'h00, 16'h0000));
    run_program(2, -1, 1'b0, 32'h0, "wrap_loop");
    write_word(PW'(0), mk(4'hF, 8'h00, 16'h0000));
    write_word(PW'(62), mk(4'h3, 8'h3E, 16'h00AA));
    write_word(PW'(1), mk(4'h8, 8'h00, 16'hFFFE));
    run_program(2, -1, 1'b0, 32'h0, "halt_at_0");
    n_cmp++;
    if (pc !== 6'd0 || halted !== 1'b1) begin
      n_bad++;
      $display("FAIL halt_at_0 pc/halted: got %0d/%b expected 0/1", pc, halted);
    end
  endtask

  task automatic test_busy_ignored();
    write_word(PW'(0), mk(4'h2, 8'h10, 16'h0101));
    write_word(PW'(1), mk(4'h3, 8'h20, 16'h0202));
    write_word(PW'(2), mk(4'h4, 8'h30, 16'h0303));
    write_word(PW'(3), mk(4'hF, 8'h00, 16'h0000));
    run_program(2, 3, 1'b0, 32'h0, "busy_inject");
    run_program(2, -1, 1'b0, 32'h0, "busy_readback");
  endtask

  task automatic test_coincide();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_cmd = '0; last_num = '0; last_addr = '0;
    run_program(2, -1, 1'b1, mk(4'h3, 8'h44, 16'h1234), "start_with_write");
  endtask

  task automatic test_reset_mid_issue();
    write_word(PW'(0), mk(4'h3, 8'h21, 16'hBEEF));
    write_word(PW'(1), mk(4'hF, 8'h00, 16'h0000));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    n_cmp++;
    if ({issue_valid, command} !== {1'b1, 16'h3000}) begin
      n_bad++;
      $display("FAIL mid_issue before reset valid/cmd: got %b/%h expected 1/3000", issue_valid, command);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (observed() !== 57'd0) begin
      n_bad++;
      $display("FAIL mid_issue async reset outputs: got %h expected 0", observed());
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (observed() !== 57'd0) begin
      n_bad++;
      $display("FAIL mid_issue after release outputs: got %h expected 0", observed());
    end
    @(posedge clk); #1;
    last_cmd = '0; last_num = '0; last_addr = '0;
    run_program(2, -1, 1'b0, 32'h0, "rerun_after_reset");
  endtask

  task automatic test_random();
    logic [3:0] ops [10];
    ops = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hA, 4'hF, 4'h5, 4'hC};
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < DEPTH; i++) begin
        write_word(PW'(i), {ops[$urandom_range(0, 9)], 8'($urandom), 4'($urandom), 16'($urandom)});
      end
      run_program(2, -1, 1'b0, 32'h0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_compute_halt();
    test_branch();
    test_wrap();
    test_busy_ignored();
    test_coincide();
    test_reset_mid_issue();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
